// File: rtl/paddle_emu_pkg.sv
// Shared definitions for the paddle capacitor emulator: per-channel source
// mode encoding and the signed-to-offset-binary helper used by the analog modes.
package paddle_emu_pkg;

   typedef logic [1:0] paddle_mode_t;

   localparam paddle_mode_t MODE_DIGITAL = 2'd0;
   localparam paddle_mode_t MODE_AY      = 2'd1;
   localparam paddle_mode_t MODE_AX      = 2'd2;
   localparam paddle_mode_t MODE_PADDLE  = 2'd3;

   // Two's complement -128..127 maps to 0..255 by flipping the sign bit.
   function automatic logic [7:0] to_offset_binary(input logic [7:0] value);
      return {~value[7], value[6:0]};
   endfunction

endpackage

// File: rtl/paddle_emu_chan.sv
// One channel of the paddle capacitor emulator: digital position register,
// per-frame source selection, countdown of the loaded count once per line,
// and the bat-input decode (high once the count reaches zero).
// Optional acceleration of digital movement is built when PADDLE_ACCEL_EN is
// defined; otherwise the step input is used as-is and no hold counter exists.
// POS_W is expected to be at least 8 so a full step fits the position adder.
module paddle_emu_chan
   import paddle_emu_pkg::*;
#(
   parameter int POS_W      = 8,
   parameter int CAP_W      = 10,
   parameter int CAP_OFFSET = 0,
   parameter int POS_INIT   = 128,
   parameter int ACCEL_MAX  = 8
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             hs_rise,
   input  logic             vs_rise,
   input  paddle_mode_t     mode,
   input  logic             invert,
   input  logic [4:0]       step,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic [15:0]      analog,
   input  logic [7:0]       paddle,
   output logic             pin_in,
   output logic [POS_W-1:0] pos
);

   // Wide enough for a 5-bit step plus the largest acceleration bonus.
   localparam int STEP_W = $clog2(32 + ACCEL_MAX);
   localparam logic [32:0] CAP_SAT = (33'd1 << CAP_W) - 33'd1;

   logic [CAP_W-1:0] cap;
   logic [7:0]       src8;
   logic [POS_W-1:0] ext8;
   logic [POS_W-1:0] src;
   logic [POS_W-1:0] src_x;
   logic [32:0]      load_sum;
   logic [CAP_W-1:0] cap_load;
   logic [STEP_W-1:0] eff_step;
   logic [POS_W:0]   step_w;
   logic [POS_W:0]   pos_sum;
   logic [POS_W-1:0] pos_next;

   // Pick the 8-bit external source for the non-digital modes.
   always_comb begin
      src8 = paddle;
      case (mode)
         MODE_AY: src8 = to_offset_binary(analog[15:8]);
         MODE_AX: src8 = to_offset_binary(analog[7:0]);
         default: src8 = paddle;
      endcase
   end

   // 8-bit sources sit in the top bits of a wider position, zero-filled below.
   generate
      if (POS_W >= 8) begin : g_wide
         assign ext8 = POS_W'(src8) << (POS_W - 8);
      end else begin : g_narrow
         assign ext8 = POS_W'(src8 >> (8 - POS_W));
      end
   endgenerate

   // The digital source is the position as it stood before this frame's move.
   assign src   = (mode == MODE_DIGITAL) ? pos : ext8;
   assign src_x = src ^ {POS_W{invert}};

   // Loaded line count: source plus vertical bias, clamped to the counter range.
   always_comb begin
      load_sum = 33'(src_x) + 33'(CAP_OFFSET);
      cap_load = (load_sum > CAP_SAT) ? {CAP_W{1'b1}} : load_sum[CAP_W-1:0];
   end

`ifdef PADDLE_ACCEL_EN
   localparam int HOLD_MAX = 4 * ACCEL_MAX;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] boost;

   // Bonus grows by one every four frames of held movement, up to ACCEL_MAX.
   always_comb begin
      boost    = ((hold >> 2) > HOLD_W'(ACCEL_MAX)) ? HOLD_W'(ACCEL_MAX) : (hold >> 2);
      eff_step = STEP_W'(step) + STEP_W'(boost);
   end

   // Count frames with exactly one direction held; any other combination restarts.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hold <= '0;
      end else if (vs_rise) begin
         if (btn_up ^ btn_down) begin
            if (hold != HOLD_W'(HOLD_MAX)) hold <= hold + 1'b1;
         end else begin
            hold <= '0;
         end
      end
   end
`else
   assign eff_step = STEP_W'(step);
`endif

   // Saturating position move; only digital mode tracks the buttons.
   always_comb begin
      step_w   = (POS_W + 1)'(eff_step);
      pos_sum  = {1'b0, pos} + step_w;
      pos_next = pos;
      if (mode == MODE_DIGITAL && (btn_up ^ btn_down)) begin
         if (btn_up) begin
            pos_next = (step_w > {1'b0, pos}) ? '0 : (pos - step_w[POS_W-1:0]);
         end else begin
            pos_next = pos_sum[POS_W] ? {POS_W{1'b1}} : pos_sum[POS_W-1:0];
         end
      end
   end

   // Frame load beats line countdown; the count parks at zero.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         pos <= POS_W'(POS_INIT);
         cap <= '0;
      end else if (vs_rise) begin
         pos <= pos_next;
         cap <= cap_load;
      end else if (hs_rise && cap != '0) begin
         cap <= cap - 1'b1;
      end
   end

   assign pin_in = (cap == '0);

endmodule

// File: rtl/paddle_cap_emu.sv
// N-channel emulation of the AY-3-8500 bat-position RC timing input.
// Shared hsync/vsync rising-edge detection feeds one paddle_emu_chan per
// channel. Build option: PADDLE_ACCEL_EN enables held-button acceleration.
module paddle_cap_emu
   import paddle_emu_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int POS_W      = 8,
   parameter int CAP_W      = 10,
   parameter int CAP_OFFSET = 0,
   parameter int POS_INIT   = 128,
   parameter int ACCEL_MAX  = 8
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic                    hs,
   input  logic                    vs,
   input  logic [2*NUM_CH-1:0]     mode,
   input  logic [NUM_CH-1:0]       invert,
   input  logic [5*NUM_CH-1:0]     step,
   input  logic [NUM_CH-1:0]       btn_up,
   input  logic [NUM_CH-1:0]       btn_down,
   input  logic [16*NUM_CH-1:0]    analog,
   input  logic [8*NUM_CH-1:0]     paddle,
   output logic [NUM_CH-1:0]       pin_in,
   output logic [POS_W*NUM_CH-1:0] pos
);

   logic hs_old;
   logic vs_old;
   logic hs_rise;
   logic vs_rise;

   // Previous sync levels for rising-edge detection.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hs_old <= 1'b0;
         vs_old <= 1'b0;
      end else begin
         hs_old <= hs;
         vs_old <= vs;
      end
   end

   assign hs_rise = hs & ~hs_old;
   assign vs_rise = vs & ~vs_old;

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
         paddle_emu_chan #(
            .POS_W      (POS_W),
            .CAP_W      (CAP_W),
            .CAP_OFFSET (CAP_OFFSET),
            .POS_INIT   (POS_INIT),
            .ACCEL_MAX  (ACCEL_MAX)
         ) u_chan (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .hs_rise  (hs_rise),
            .vs_rise  (vs_rise),
            .mode     (paddle_mode_t'(mode[2*i +: 2])),
            .invert   (invert[i]),
            .step     (step[5*i +: 5]),
            .btn_up   (btn_up[i]),
            .btn_down (btn_down[i]),
            .analog   (analog[16*i +: 16]),
            .paddle   (paddle[8*i +: 8]),
            .pin_in   (pin_in[i]),
            .pos      (pos[POS_W*i +: POS_W])
         );
      end
   endgenerate

endmodule
